// File: rtl/comp4_arb_pkg.sv
// Shared types and constants for the comp4 round-robin arbiter slice.
package comp4_arb_pkg;

  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Requester ID width; a single-requester build still gets one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comp4.sv
// Unsigned 4-bit magnitude comparator shared by all requesters.
module comp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/comp4_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module comp4_rr_pick import comp4_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    logic [IDW-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!any && req_valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/comp4_arbiter.sv
// Round-robin scheduler sharing one comp4 between NREQ valid/ready requesters.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offers the round-robin grant
// CMP   | latched operands drive comp4; flags get registered
// RESP  | result held on rsp_* until rsp_ready
module comp4_arbiter import comp4_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_eq,
  output logic              rsp_gt,
  output logic              rsp_lt,
  output logic              busy
);

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [3:0]     a_q;
  logic [3:0]     b_q;
  logic [IDW-1:0] id_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            cmp_eq;
  logic            cmp_gt;
  logic            cmp_lt;

  comp4_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  comp4 u_comp4 (
    .a  (a_q),
    .b  (b_q),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Grant is only offered in IDLE, and forced low while reset is held.
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_eq    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            a_q    <= req_a[{pick_idx, 2'b00} +: 4];
            b_q    <= req_b[{pick_idx, 2'b00} +: 4];
            id_q   <= pick_idx;
            rr_ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
            state  <= CMP;
          end
        end
        CMP: begin
          rsp_eq    <= cmp_eq;
          rsp_gt    <= cmp_gt;
          rsp_lt    <= cmp_lt;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/comp4_arbiter.md
# comp4_arbiter

Round-robin scheduler that shares a single `comp4` 4-bit magnitude comparator between up to `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter captures the winning pair, runs it through the shared comparator, and returns registered eq/gt/lt flags tagged with the requester ID under a second valid/ready handshake. It sits between the requesting datapath blocks and the one `comp4` instance, which it instantiates internally.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: ID width. Derived; not overridden.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  4*NREQ  operand A; requester i occupies bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot accept to the granted requester; all-zero otherwise.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_eq`, `rsp_gt`, `rsp_lt`  out  1 each  comparison of A against B; exactly one is high while `rsp_valid`=1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM has three states: IDLE, CMP, RESP.
- **IDLE**
  - Grant goes to the first requester with `req_valid`=1, searching upward from `rr_ptr` with wrap (`rr_ptr`, `rr_ptr`+1, …, NREQ-1, 0, …).
  - `req_ready[g]`=1 combinationally, only for the granted index g.
  - On the accept (`req_valid[g]` & `req_ready[g]`): latch `a`, `b` and `id`=g; set `rr_ptr` ← (g+1) mod NREQ; go to CMP.
  - With no valid requests, stay in IDLE and leave `rr_ptr` unchanged.
- **CMP**
  - The latched a/b drive the `comp4` instance.
  - Its eq/gt/lt outputs are registered into `rsp_eq`/`rsp_gt`/`rsp_lt`.
  - `rsp_valid` ← 1; go to RESP.
- **RESP**
  - `rsp_*` are held stable until `rsp_ready`=1.
  - On the response handshake: `rsp_valid` ← 0; go to IDLE.
- `req_ready` is all-zero in CMP and RESP. Only one transaction is in flight at a time.
- Comparison is unsigned, 4-bit. For example, a=4'hF, b=4'h0 gives gt=1.
- A requester may drop `req_valid` before it is granted. The arbiter does not remember it.
- `rsp_ready` while `rsp_valid`=0 is ignored.
- **Reset** (`rst_n`=0 at a rising edge, including mid-transaction):
  - Any in-flight transaction is discarded.
  - State ← IDLE, `rr_ptr` ← 0.
  - `rsp_valid`, `rsp_eq`, `rsp_gt`, `rsp_lt`, `rsp_id`, `busy` ← 0; `req_ready` reads 0 while `rst_n`=0.
  - Latched a/b/id ← 0.

## Timing
- Accept edge T (IDLE → CMP); result registered at T+1; `rsp_valid`=1 from T+1 onward.
- If `rsp_ready`=1 at T+2, the FSM is back in IDLE after T+2 and can accept a new request at edge T+3.
- Minimum issue interval is 3 cycles. Peak throughput is 1 result per 3 cycles.
- Backpressure: each cycle `rsp_ready`=0 in RESP adds one cycle; outputs do not change.
- Simultaneous request and response events cannot overlap, because `req_ready` is low outside IDLE.
- Fairness: a continuously valid requester is granted within NREQ transactions.

## Structure
- Shared package `comp4_arb_pkg`:
  - state enum `{IDLE, CMP, RESP}`, 2-bit encoding;
  - `NREQ_MAX`=8;
  - a helper function for the ID width.
- Sub-module `comp4_rr_pick`: purely combinational round-robin priority picker.
  - Inputs: `req_valid` and `rr_ptr`.
  - Outputs: one-hot grant, encoded index, and `any`.
- One `comp4` instance inside `comp4_arbiter`; no other comparator logic.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles with all `req_valid`=1 → `req_ready`=0, `rsp_valid`=0, `busy`=0; after release, first grant goes to requester 0.
- **Single request:** req0 a=4'h9, b=4'h3, `rsp_ready`=1 → `rsp_valid` at T+1 with id=0, gt=1, eq=0, lt=0; FSM back in IDLE at T+3.
- **Round-robin order:** all 4 valid continuously; operand pairs (5,5), (2,7), (F,0), (0,0) → grants in order 0,1,2,3,0; results eq, lt, gt, eq.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` → id and flags stable, `req_ready`=0 throughout; completion on the 6th cycle.
- **Pointer wrap:** `rr_ptr`=3 with only req1 and req3 valid → grant 3, then 1; `rr_ptr` becomes 0, then 2.
- **Reset mid-operation:** assert `rst_n`=0 in RESP holding id=2 → `rsp_valid`=0 next edge, no response for id 2 is ever delivered, `rr_ptr`=0.
